// File: rtl/cam_pkg.sv
// Shared types and default sizes for the CAM write-side decoder.
// Optional feature macro used by the decoder: CAM_WRITE_PROTECT_EN.
package cam_pkg;

  // Default geometry: 32 entries of 32-bit keys.
  localparam int CAM_INDEX_WIDTH = 5;
  localparam int CAM_KEY_WIDTH   = 32;

  // Request opcodes as carried on req_op_i.
  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_INVALIDATE = 2'b01,
    OP_CLEAR_ALL  = 2'b10,
    OP_RSVD       = 2'b11
  } cam_op_e;

  // Decoder control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_SWEEP = 2'b10
  } cam_dec_state_e;

endpackage

// File: rtl/onehotdecoder.sv
// Combinational binary index to one-hot wordline expander.
module onehotdecoder #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic [INDEX_WIDTH-1:0]      i_index,
  output logic [(1<<INDEX_WIDTH)-1:0] o_onehot
);

  // Exactly one bit set, at the position named by the index.
  always_comb begin
    o_onehot          = '0;
    o_onehot[i_index] = 1'b1;
  end

endmodule

// File: rtl/cam_index_decoder.sv
// CAM write-side index decoder: expands an entry index into a one-hot
// wordline enable, keeps the per-entry valid bitmap and reports the lowest
// free entry. Serialises WRITE / INVALIDATE and runs a CLEAR_ALL sweep.
// Optional feature macro: CAM_WRITE_PROTECT_EN (reject WRITE to a valid entry).
//
// Request handshake: a request transfers on a rising edge where
// req_valid_i && req_ready_o. req_ready_o is high only in IDLE and never
// while rst is high; the requester holds every req_* field stable until the
// transfer edge. Requests presented in ISSUE or SWEEP have no effect.
module cam_index_decoder
  import cam_pkg::*;
#(
  parameter int INDEX_WIDTH = CAM_INDEX_WIDTH,
  parameter int KEY_WIDTH   = CAM_KEY_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [INDEX_WIDTH-1:0]      req_index_i,
  input  logic [KEY_WIDTH-1:0]        req_key_i,
  output logic [(1<<INDEX_WIDTH)-1:0] wl_en_o,
  output logic [KEY_WIDTH-1:0]        wr_key_o,
  output logic                        wr_set_o,
  output logic [(1<<INDEX_WIDTH)-1:0] entry_valid_o,
  output logic [INDEX_WIDTH-1:0]      free_index_o,
  output logic                        full_o,
  output logic                        done_o,
  output logic                        err_o,
  output cam_dec_state_e              dbg_state_o
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  // Control and datapath registers.
  cam_dec_state_e         r_state;
  cam_op_e                r_op;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [INDEX_WIDTH-1:0] r_cnt;
  logic [DEPTH-1:0]       r_valid;

  // Combinational helpers.
  logic [INDEX_WIDTH-1:0] w_dec_idx;
  logic [DEPTH-1:0]       w_onehot;
  logic                   w_last;
  logic                   w_reject;
  logic                   w_accept;
  logic [INDEX_WIDTH-1:0] w_free;
  logic                   w_full;

  assign w_accept = req_valid_i && req_ready_o;
  assign w_last   = &r_cnt;

  // A single decoder serves both paths: the sweep counter drives it during
  // SWEEP, the latched request index otherwise.
  assign w_dec_idx = (r_state == ST_SWEEP) ? r_cnt : r_index;

  onehotdecoder #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_onehotdecoder (
    .i_index  (w_dec_idx),
    .o_onehot (w_onehot)
  );

`ifdef CAM_WRITE_PROTECT_EN
  // A WRITE landing on an already-valid entry is refused.
  assign w_reject = (r_state == ST_ISSUE) && (r_op == OP_WRITE) && r_valid[r_index];
`else
  assign w_reject = 1'b0;
`endif

  // Control FSM, request latches, sweep counter and valid bitmap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_WRITE;
      r_index <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cam_op_e'(req_op_i) == OP_CLEAR_ALL) begin
              r_cnt   <= '0;
              r_state <= ST_SWEEP;
            end else begin
              r_op    <= cam_op_e'(req_op_i);
              r_index <= req_index_i;
              r_key   <= req_key_i;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          case (r_op)
            OP_WRITE: begin
              if (!w_reject) begin
                r_valid[r_index] <= 1'b1;
              end
            end
            OP_INVALIDATE: r_valid[r_index] <= 1'b0;
            default: ;
          endcase
          r_state <= ST_IDLE;
        end
        ST_SWEEP: begin
          r_valid[r_cnt] <= 1'b0;
          r_cnt          <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Wordline side outputs, decoded purely from registered state so they are
  // stable for the whole cycle. Rejected and reserved ops drive no wordline.
  always_comb begin
    wl_en_o  = '0;
    wr_key_o = '0;
    wr_set_o = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        done_o = 1'b1;
        err_o  = w_reject;
        if (r_op == OP_WRITE && !w_reject) begin
          wl_en_o  = w_onehot;
          wr_key_o = r_key;
          wr_set_o = 1'b1;
        end else if (r_op == OP_INVALIDATE) begin
          wl_en_o = w_onehot;
        end
      end
      ST_SWEEP: begin
        wl_en_o = w_onehot;
        done_o  = w_last;
      end
      default: ;
    endcase
  end

  // Lowest-index free entry; reports 0 when every entry is valid.
  always_comb begin
    w_free = '0;
    w_full = &r_valid;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free = INDEX_WIDTH'(i);
      end
    end
  end

  assign req_ready_o   = (r_state == ST_IDLE) && !rst;
  assign entry_valid_o = r_valid;
  assign free_index_o  = w_free;
  assign full_o        = w_full;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_cam_index_decoder.sv
// Self-checking bench for cam_index_decoder (default geometry 32 x 32-bit).
module tb_cam_index_decoder;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op    = 2'b00;
  logic [4:0]  req_index = '0;
  logic [31:0] req_key   = '0;
  logic [31:0] wl_en;
  logic [31:0] wr_key;
  logic        wr_set;
  logic [31:0] entry_valid;
  logic [4:0]  free_index;
  logic        full;
  logic        done;
  logic        err;
  cam_pkg::cam_dec_state_e dbg_state;

  cam_index_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_index_i   (req_index),
    .req_key_i     (req_key),
    .wl_en_o       (wl_en),
    .wr_key_o      (wr_key),
    .wr_set_o      (wr_set),
    .entry_valid_o (entry_valid),
    .free_index_o  (free_index),
    .full_o        (full),
    .done_o        (done),
    .err_o         (err),
    .dbg_state_o   (dbg_state)
  );

  // Scoreboard: {wl_en, wr_key, wr_set, err} expected at each done pulse
  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_valid = '0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op");
      end else begin
        check("done_outputs", {wl_en, wr_key, wr_set, err}, exp_q.pop_front());
      end
    end else if (!rst && err) begin
      n_checks++;
      n_fail++;
      $display("FAIL err_without_done: got err_o=1 expected 0");
    end
  end

  // Driver: wait for ready, present one request, drop valid after transfer
  task automatic do_op(input logic [1:0] op, input logic [4:0] idx,
                       input logic [31:0] key, input logic [65:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready_o=0 expected 1 within 50 cycles");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_key   = key;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Write every entry the model shows as free
  task automatic fill_all();
    for (int i = 0; i < 32; i++) begin
      if (!m_valid[i]) begin
        do_op(2'b00, 5'(i), 32'h100 + 32'(i),
              {32'h1 << i, 32'h100 + 32'(i), 1'b1, 1'b0});
        @(negedge clk);
        m_valid[i] = 1'b1;
      end
    end
    @(negedge clk);
    check("fill_valid", 66'(entry_valid), 66'(32'hFFFF_FFFF));
    check("fill_full",  66'(full), 66'(1'b1));
    check("fill_free",  66'(free_index), 66'(5'd0));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] key;
    logic [31:0] exp_wl;
    logic [31:0] exp_key;
    logic        exp_set;
    logic        exp_err;
    logic [31:0] exp_valid;
    logic [4:0]  exp_free;
    logic        exp_full;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
`ifdef CAM_WRITE_PROTECT_EN
    vecs[7] = '{2'b00, 5'd7, 32'h78, 32'h0,  32'h0,  1'b0, 1'b1, 32'h8A, 5'd0, 1'b0};
`else
    vecs[7] = '{2'b00, 5'd7, 32'h78, 32'h80, 32'h78, 1'b1, 1'b0, 32'h8A, 5'd0, 1'b0};
`endif
    vecs[0] = '{2'b00, 5'd3, 32'hDEADBEEF, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 32'h08, 5'd0, 1'b0};
    vecs[1] = '{2'b00, 5'd0, 32'h11, 32'h1,  32'h11, 1'b1, 1'b0, 32'h09, 5'd1, 1'b0};
    vecs[2] = '{2'b00, 5'd1, 32'h22, 32'h2,  32'h22, 1'b1, 1'b0, 32'h0B, 5'd2, 1'b0};
    vecs[3] = '{2'b01, 5'd0, 32'h33, 32'h1,  32'h0,  1'b0, 1'b0, 32'h0A, 5'd0, 1'b0};
    vecs[4] = '{2'b01, 5'd0, 32'h44, 32'h1,  32'h0,  1'b0, 1'b0, 32'h0A, 5'd0, 1'b0};
    vecs[5] = '{2'b11, 5'd4, 32'h55, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0A, 5'd0, 1'b0};
    vecs[6] = '{2'b00, 5'd7, 32'h77, 32'h80, 32'h77, 1'b1, 1'b0, 32'h8A, 5'd0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 66'(req_ready), 66'(1'b0));
    check("rst_outputs", {wl_en, wr_key, wr_set, err}, 66'(0));
    check("rst_valid", 66'({entry_valid, free_index, full, done}), 66'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 66'(req_ready), 66'(1'b1));

    // Table-driven single-entry ops
    for (int v = 0; v < 8; v++) begin
      do_op(vecs[v].op, vecs[v].idx, vecs[v].key,
            {vecs[v].exp_wl, vecs[v].exp_key, vecs[v].exp_set, vecs[v].exp_err});
      @(negedge clk);
      @(negedge clk);
      check("vec_valid", 66'(entry_valid), 66'(vecs[v].exp_valid));
      check("vec_free",  66'(free_index),  66'(vecs[v].exp_free));
      check("vec_full",  66'(full),        66'(vecs[v].exp_full));
    end
    m_valid = 32'h8A;

    // Fill, then CLEAR_ALL with a WRITE to 5 held pending during the sweep
    fill_all();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_index = 5'd0;
    req_key   = 32'h0;
    exp_q.push_back({32'h8000_0000, 32'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    req_op    = 2'b00;
    req_index = 5'd5;
    req_key   = 32'h0000_5A5A;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("sweep_wl", 66'(wl_en), 66'(32'h1 << i));
      check("sweep_ready", 66'(req_ready), 66'(1'b0));
      check("sweep_done", 66'(done), 66'(i == 31));
    end
    @(negedge clk);
    check("clear_valid", 66'(entry_valid), 66'(0));
    check("clear_full", 66'(full), 66'(1'b0));
    check("clear_ready", 66'(req_ready), 66'(1'b1));
    exp_q.push_back({32'h20, 32'h0000_5A5A, 1'b1, 1'b0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (wl_en == 32'h20) pulses++;
    end
    check("pending_write_pulses", 66'(pulses), 66'(1));
    check("pending_write_valid", 66'(entry_valid), 66'(32'h20));
    m_valid = 32'h20;

    // Reset on sweep cycle 10 with every entry valid
    fill_all();
    do_op(2'b10, 5'd0, 32'h0, {32'h8000_0000, 32'h0, 1'b0, 1'b0});
    repeat (10) @(negedge clk);
    check("abort_sweep_wl", 66'(wl_en), 66'(32'h1 << 9));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", 66'(entry_valid), 66'(0));
    check("abort_wl", 66'(wl_en), 66'(0));
    check("abort_done", 66'(done), 66'(1'b0));
    check("abort_ready_in_rst", 66'(req_ready), 66'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 66'(req_ready), 66'(1'b1));
    repeat (40) @(negedge clk);
    check("abort_no_done", 66'(done), 66'(1'b0));
    check("queue_empty", 66'(exp_q.size()), 66'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_index_decoder.md
# cam_index_decoder

Write-side counterpart of the CAM match path. Where the match path reduces a match vector to an index, this block expands an index into a one-hot CAM wordline enable, tracks per-entry valid bits, and reports the lowest free entry for allocation. It sits between the parser's table-update logic and the CAM storage array. It serialises single-entry writes and invalidates, plus a multi-cycle clear-all sweep.

## Interface
- INDEX_WIDTH, 5, entry index width; depth = 1 << INDEX_WIDTH
- KEY_WIDTH, 32, CAM key width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_op_i  in  2  00 WRITE, 01 INVALIDATE, 10 CLEAR_ALL, 11 reserved
- req_index_i  in  INDEX_WIDTH  target entry (ignored for CLEAR_ALL)
- req_key_i  in  KEY_WIDTH  key to write (WRITE only)
- wl_en_o  out  1<<INDEX_WIDTH  one-hot wordline enable to CAM array
- wr_key_o  out  KEY_WIDTH  key driven with wl_en_o
- wr_set_o  out  1  1 = mark entry valid, 0 = mark invalid
- entry_valid_o  out  1<<INDEX_WIDTH  registered valid bitmap
- free_index_o  out  INDEX_WIDTH  lowest index with valid bit 0
- full_o  out  1  all entries valid
- done_o  out  1  single-cycle pulse on operation completion
- err_o  out  1  single-cycle pulse on rejected write

## Operation
- States: IDLE, ISSUE, SWEEP.
- Handshake: a request is accepted when req_valid_i && req_ready_o. req_ready_o = 1 only in IDLE and not in rst. The requester holds all req_* fields stable until acceptance.
- Accept of WRITE or INVALIDATE: index, key and op are latched; transition to ISSUE.
- ISSUE (one cycle):
  - wl_en_o = one-hot(latched index).
  - wr_key_o = latched key for WRITE, 0 for INVALIDATE.
  - wr_set_o = 1 for WRITE, 0 for INVALIDATE.
  - The valid bit updates at the end of the cycle.
  - done_o = 1.
  - Next state is IDLE.
- Accept of CLEAR_ALL: the sweep counter loads 0; transition to SWEEP.
- SWEEP:
  - Each cycle: wl_en_o = one-hot(counter), wr_key_o = 0, wr_set_o = 0, and that entry's valid bit clears.
  - At counter = depth-1: done_o = 1, then return to IDLE, and the counter wraps to 0.
- Reserved op: accepted, no wordline activity, done_o pulses the next cycle (via ISSUE with wl_en_o = 0).
- free_index_o / full_o:
  - Both are combinational from the registered bitmap and are lowest-index-first.
  - When full_o = 1, free_index_o = 0.
- Outside ISSUE and SWEEP: wl_en_o = 0, wr_key_o = 0, wr_set_o = 0.

## Timing
- Reset values: state IDLE, entry_valid_o = 0, wl_en_o = 0, wr_key_o = 0, wr_set_o = 0, done_o = 0, err_o = 0, full_o = 0, free_index_o = 0, req_ready_o = 0 while rst is high and 1 on the first cycle after.
- Latency:
  - WRITE/INVALIDATE: wordline and done_o one cycle after acceptance; entry_valid_o reflects the change two cycles after acceptance. Throughput is one op per 2 cycles.
  - CLEAR_ALL: depth cycles of SWEEP; done_o on the last one. Earliest next acceptance is the cycle after done_o.
- Request during ISSUE or SWEEP: not accepted, no side effect.
- Invalidating an already-invalid entry is legal: wordline still fires, bitmap unchanged.
- Reset mid-SWEEP or mid-ISSUE aborts the operation. The next cycle shows reset values, and no done_o is issued for the aborted op.

## Configuration
- CAM_WRITE_PROTECT_EN defined: a WRITE whose target valid bit is already 1 is rejected. In ISSUE, wl_en_o = 0 and the bitmap is unchanged; err_o = 1 and done_o = 1 in the same cycle.
- Not defined: the WRITE overwrites the entry normally and err_o is tied to 0.

## Structure
- Shared package cam_pkg holds:
  - cam_op_e (WRITE, INVALIDATE, CLEAR_ALL, RSVD);
  - the decoder state enum (IDLE, ISSUE, SWEEP);
  - default constants CAM_INDEX_WIDTH = 5 and CAM_KEY_WIDTH = 32.
- One sub-module, onehotdecoder (parameter INDEX_WIDTH, combinational index -> one-hot). It is instantiated once and muxed between the latched index and the sweep counter.

## Test plan
- Reset, then WRITE index 3 key 0xDEADBEEF -> the next cycle shows wl_en_o = 0x00000008, wr_key_o = 0xDEADBEEF, wr_set_o = 1, done_o = 1. The cycle after, entry_valid_o = 0x00000008 and free_index_o = 0.
- WRITE index 0, then WRITE index 1 -> free_index_o = 2. INVALIDATE 0 -> free_index_o = 0, entry_valid_o = 0x0000000A (with index 3 still set).
- Fill all 32 entries -> full_o = 1, free_index_o = 0. CLEAR_ALL -> 32 SWEEP cycles with wl_en_o walking 0x1..0x80000000, done_o on cycle 32, then entry_valid_o = 0 and full_o = 0.
- req_valid_i held high during SWEEP with a WRITE to 5 -> not accepted until after done_o. It then completes with exactly one wl_en_o = 0x20 pulse.
- rst asserted on SWEEP cycle 10 with all entries valid -> the next cycle has entry_valid_o = 0, wl_en_o = 0, no done_o, and req_ready_o = 1 after rst drops.
- With CAM_WRITE_PROTECT_EN, WRITE index 7 twice -> the second shows err_o = 1, done_o = 1, wl_en_o = 0. Without the macro, the second write fires wl_en_o = 0x80 with err_o = 0.
